// File: rtl/ifetch_prefetch_if.sv
// Signal bundle between the fetch front-end, instruction memory and the core.
// The master side is the fetch unit; the slave side is the memory/core environment.
interface ifetch_prefetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_out;
  logic [31:0] inst_pc;

  modport master (
    output imem_req, imem_addr, inst_valid, inst_out, inst_pc,
    input  imem_rvalid, imem_rdata, redirect_valid, redirect_pc, inst_ready
  );

  modport slave (
    input  imem_req, imem_addr, inst_valid, inst_out, inst_pc,
    output imem_rvalid, imem_rdata, redirect_valid, redirect_pc, inst_ready
  );
endinterface

// File: rtl/ifetch_prefetch.sv
// Instruction prefetch front-end: runs the fetch PC, keeps at most one read in flight
// to instruction memory and buffers returned {PC, instruction} pairs for the core.
module ifetch_prefetch #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic               clk,
  input logic               rst,
  ifetch_prefetch_if.master bus
);
  localparam int unsigned   AW      = $clog2(DEPTH);
  localparam int unsigned   CW      = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [31:0]   NOP     = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DROP
  } state_e;

  state_e        state_q, state_d;
  logic [31:0]   fetchPc_q, fetchPc_d;
  logic [31:0]   reqPc_q, reqPc_d;
  logic [AW-1:0] wrPtr_q, wrPtr_d;
  logic [AW-1:0] rdPtr_q, rdPtr_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] countAfterPush;
  logic [31:0]   instMem_q [DEPTH];
  logic [31:0]   pcMem_q   [DEPTH];
  logic          headValid, push, pop, issue, busyAfter;

  always_comb begin
    headValid      = (count_q != '0);
    push           = (state_q == S_WAIT) && bus.imem_rvalid && !bus.redirect_valid;
    pop            = headValid && bus.inst_ready && !bus.redirect_valid;
    busyAfter      = (state_q != S_IDLE) && !bus.imem_rvalid;
    countAfterPush = count_q + {{AW{1'b0}}, push};
    // This cycle's pop is not credited, keeping inst_ready off the imem_req path.
    issue          = !rst && !bus.redirect_valid && !busyAfter && (countAfterPush < DEPTH_C);
  end

  always_comb begin
    state_d   = state_q;
    fetchPc_d = fetchPc_q;
    reqPc_d   = reqPc_q;
    wrPtr_d   = wrPtr_q;
    rdPtr_d   = rdPtr_q;
    count_d   = count_q;

    case (state_q)
      S_IDLE: begin
        if (issue) state_d = S_WAIT;
      end
      S_WAIT, S_DROP: begin
        if (bus.imem_rvalid)         state_d = issue ? S_WAIT : S_IDLE;
        else if (bus.redirect_valid) state_d = S_DROP;
      end
      default: state_d = S_IDLE;
    endcase

    if (issue) begin
      reqPc_d   = fetchPc_q;
      fetchPc_d = fetchPc_q + 32'd4;
    end

    if (bus.redirect_valid) begin
      fetchPc_d = bus.redirect_pc & 32'hFFFF_FFFC;
      wrPtr_d   = '0;
      rdPtr_d   = '0;
      count_d   = '0;
    end else begin
      if (push) wrPtr_d = wrPtr_q + AW'(1);
      if (pop)  rdPtr_d = rdPtr_q + AW'(1);
      count_d = count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      fetchPc_q <= RESET_PC;
      reqPc_q   <= RESET_PC;
      wrPtr_q   <= '0;
      rdPtr_q   <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      fetchPc_q <= fetchPc_d;
      reqPc_q   <= reqPc_d;
      wrPtr_q   <= wrPtr_d;
      rdPtr_q   <= rdPtr_d;
      count_q   <= count_d;
    end
  end

  // Storage needs no reset: an entry is only visible once count covers it.
  always_ff @(posedge clk) begin
    if (push) begin
      instMem_q[wrPtr_q] <= bus.imem_rdata;
      pcMem_q[wrPtr_q]   <= reqPc_q;
    end
  end

  assign bus.imem_req   = issue;
  assign bus.imem_addr  = fetchPc_q;
  assign bus.inst_valid = headValid;
  assign bus.inst_out   = headValid ? instMem_q[rdPtr_q] : NOP;
  assign bus.inst_pc    = headValid ? pcMem_q[rdPtr_q] : 32'h0;
endmodule

// File: tb/tb_ifetch_prefetch.sv
// Self-checking bench for ifetch_prefetch: a queue-based fetch model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_ifetch_prefetch;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ifetch_prefetch_if bus ();
  ifetch_prefetch_if bus2 ();

  ifetch_prefetch #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  ifetch_prefetch #(.DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) dutWrap (
    .clk(clk), .rst(rst), .bus(bus2)
  );

  int testsRun = 0;
  int failures = 0;
  int memLat   = 1;

  logic [31:0] wrapAddr [3] = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};

  function automatic logic [31:0] instFor(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic rstV, input logic redirV, input logic [31:0] rpcV,
                               input logic readyV);
    @(posedge clk);
    #1;
    rst                = rstV;
    bus.redirect_valid = redirV;
    bus.redirect_pc    = rpcV;
    bus.inst_ready     = readyV;
    @(negedge clk);
  endtask

  task automatic resetDut(input int n, input logic readyV);
    for (int k = 0; k < n; k++) applyStimulus(1'b1, 1'b0, 32'h0, readyV);
  endtask

  // Memory model: every request answers memLat cycles later with instFor(addr).
  typedef struct {
    logic [31:0] addr;
    int          rem;
  } memReq_t;
  memReq_t     memQ[$];
  logic        memNextValid = 1'b0;
  logic [31:0] memNextData  = 32'h0;
  logic        mem2Valid    = 1'b0;
  logic [31:0] mem2Data     = 32'h0;

  always @(posedge clk) begin
    #1;
    bus.imem_rvalid  = memNextValid;
    bus.imem_rdata   = memNextData;
    bus2.imem_rvalid = mem2Valid;
    bus2.imem_rdata  = mem2Data;
  end

  // Reference model: fetch PC, one outstanding request, queue of buffered PCs.
  logic [31:0] mFifo[$];
  logic [31:0] mFetchPc     = RESET_PC;
  logic [31:0] mReqPc       = RESET_PC;
  bit          mOutstanding = 1'b0;
  bit          mDiscard     = 1'b0;

  always @(negedge clk) begin : cmp
    logic        expValid, delivered, keep, expReq;
    logic [31:0] expPc, expInst;
    expValid  = (mFifo.size() != 0);
    expPc     = expValid ? mFifo[0] : 32'h0;
    expInst   = expValid ? instFor(mFifo[0]) : 32'h0000_0013;
    delivered = mOutstanding && bus.imem_rvalid;
    keep      = delivered && !mDiscard && !bus.redirect_valid;
    expReq    = !rst && !bus.redirect_valid && (!mOutstanding || delivered) &&
                ((mFifo.size() + (keep ? 1 : 0)) < DEPTH);

    checkOutput("cyc imem_req", 32'(bus.imem_req), 32'(expReq));
    checkOutput("cyc imem_addr", bus.imem_addr, mFetchPc);
    checkOutput("cyc inst_valid", 32'(bus.inst_valid), 32'(expValid));
    checkOutput("cyc inst_pc", bus.inst_pc, expPc);
    checkOutput("cyc inst_out", bus.inst_out, expInst);

    if (rst) begin
      mFifo.delete();
      mOutstanding = 1'b0;
      mDiscard     = 1'b0;
      mFetchPc     = RESET_PC;
    end else begin
      if (keep) begin
        checkOutput("push into full", 32'(mFifo.size() < DEPTH), 32'd1);
        mFifo.push_back(mReqPc);
      end
      if (bus.redirect_valid) mFifo.delete();
      else if (expValid && bus.inst_ready) void'(mFifo.pop_front());
      if (delivered) mOutstanding = 1'b0;
      if (expReq) begin
        mOutstanding = 1'b1;
        mDiscard     = 1'b0;
        mReqPc       = mFetchPc;
        mFetchPc     = mFetchPc + 32'd4;
      end
      if (bus.redirect_valid) begin
        mFetchPc = bus.redirect_pc & 32'hFFFF_FFFC;
        if (mOutstanding) mDiscard = 1'b1;
      end
    end

    if (bus.imem_req === 1'b1) memQ.push_back('{addr: bus.imem_addr, rem: memLat});
    memNextValid = 1'b0;
    memNextData  = 32'hDEAD_BEEF;
    foreach (memQ[k]) memQ[k].rem = memQ[k].rem - 1;
    if (memQ.size() != 0 && memQ[0].rem <= 0) begin
      memNextValid = 1'b1;
      memNextData  = instFor(memQ[0].addr);
      void'(memQ.pop_front());
    end

    mem2Valid = (bus2.imem_req === 1'b1);
    mem2Data  = instFor(bus2.imem_addr);
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int          seenReqs;
    logic [31:0] seenAddr;
    bus.redirect_valid  = 1'b0;
    bus.redirect_pc     = 32'h0;
    bus.inst_ready      = 1'b0;
    bus.imem_rvalid     = 1'b0;
    bus.imem_rdata      = 32'h0;
    bus2.redirect_valid = 1'b0;
    bus2.redirect_pc    = 32'h0;
    bus2.inst_ready     = 1'b1;
    bus2.imem_rvalid    = 1'b0;
    bus2.imem_rdata     = 32'h0;

    // Reset values and streaming fill with a 1-cycle memory.
    memLat = 1;
    resetDut(2, 1'b1);
    checkOutput("rst imem_req", 32'(bus.imem_req), 32'd0);
    checkOutput("rst imem_addr", bus.imem_addr, 32'h0);
    checkOutput("rst inst_valid", 32'(bus.inst_valid), 32'd0);
    checkOutput("rst inst_out", bus.inst_out, 32'h0000_0013);
    checkOutput("rst inst_pc", bus.inst_pc, 32'h0);
    checkOutput("rst wrap addr", bus2.imem_addr, 32'hFFFF_FFF8);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
      checkOutput("fill imem_req", 32'(bus.imem_req), 32'd1);
      checkOutput("fill imem_addr", bus.imem_addr, 32'(4 * i));
      if (i < 3) checkOutput("wrap imem_addr", bus2.imem_addr, wrapAddr[i]);
      if (i >= 2) begin
        checkOutput("fill inst_pc", bus.inst_pc, 32'(4 * (i - 2)));
        checkOutput("fill inst_out", bus.inst_out, instFor(32'(4 * (i - 2))));
        checkOutput("wrap inst_pc", bus2.inst_pc, wrapAddr[i - 2]);
      end
    end

    // Backpressure: exactly DEPTH requests, then one refill after a single pop.
    resetDut(2, 1'b0);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
      checkOutput("bp imem_req", 32'(bus.imem_req), 32'(i < 4));
      if (i < 4) checkOutput("bp imem_addr", bus.imem_addr, 32'(4 * i));
    end
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("bp pop inst_pc", bus.inst_pc, 32'h0);
    seenReqs = 0;
    seenAddr = 32'h0;
    for (int j = 0; j < 4; j++) begin
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
      if (bus.imem_req === 1'b1) begin
        seenReqs++;
        seenAddr = bus.imem_addr;
      end
    end
    checkOutput("bp refill count", 32'(seenReqs), 32'd1);
    checkOutput("bp refill addr", seenAddr, 32'h10);
    checkOutput("bp new head", bus.inst_pc, 32'h4);
    for (int j = 0; j < 8; j++) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);

    // Three wait states: requests every fourth cycle.
    memLat = 4;
    resetDut(6, 1'b1);
    for (int i = 0; i < 13; i++) begin
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
      checkOutput("ws imem_req", 32'(bus.imem_req), 32'(i % 4 == 0));
      if (i % 4 == 0) checkOutput("ws imem_addr", bus.imem_addr, 32'(i));
      if (i == 5 || i == 9) checkOutput("ws inst_pc", bus.inst_pc, 32'((i - 5)));
    end

    // Redirect while a request is outstanding.
    resetDut(6, 1'b0);
    for (int i = 0; i < 14; i++) begin
      applyStimulus(1'b0, (i == 6), (i == 6) ? 32'h0000_0103 : 32'h0, 1'b0);
      if (i == 6)  checkOutput("rd pre inst_valid", 32'(bus.inst_valid), 32'd1);
      if (i == 7)  checkOutput("rd flush inst_valid", 32'(bus.inst_valid), 32'd0);
      if (i == 7)  checkOutput("rd drop imem_req", 32'(bus.imem_req), 32'd0);
      if (i == 8)  checkOutput("rd target req", 32'(bus.imem_req), 32'd1);
      if (i == 8)  checkOutput("rd target addr", bus.imem_addr, 32'h100);
      if (i == 13) checkOutput("rd first inst_pc", bus.inst_pc, 32'h100);
    end

    // Redirect coinciding with a response and a ready core.
    memLat = 1;
    resetDut(6, 1'b1);
    for (int i = 0; i < 7; i++) begin
      applyStimulus(1'b0, (i == 3), (i == 3) ? 32'h200 : 32'h0, 1'b1);
      if (i == 3) checkOutput("rdr head pc", bus.inst_pc, 32'h4);
      if (i == 4) checkOutput("rdr inst_valid", 32'(bus.inst_valid), 32'd0);
      if (i == 4) checkOutput("rdr target addr", bus.imem_addr, 32'h200);
      if (i == 6) checkOutput("rdr first inst_pc", bus.inst_pc, 32'h200);
    end

    // Two redirects back to back: the later target is fetched.
    memLat = 4;
    resetDut(6, 1'b1);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, (i == 1 || i == 2), (i == 1) ? 32'h300 : 32'h404, 1'b1);
      if (i == 4) checkOutput("drop last req", 32'(bus.imem_req), 32'd1);
      if (i == 4) checkOutput("drop last addr", bus.imem_addr, 32'h404);
      if (i == 9) checkOutput("drop last inst_pc", bus.inst_pc, 32'h404);
    end

    // Reset in the middle of an outstanding read.
    resetDut(6, 1'b0);
    for (int i = 0; i < 18; i++) begin
      applyStimulus((i >= 6 && i < 12), 1'b0, 32'h0, 1'b0);
      if (i == 5) checkOutput("mid pre inst_valid", 32'(bus.inst_valid), 32'd1);
      if (i == 7) begin
        checkOutput("mid rst imem_req", 32'(bus.imem_req), 32'd0);
        checkOutput("mid rst imem_addr", bus.imem_addr, 32'h0);
        checkOutput("mid rst inst_valid", 32'(bus.inst_valid), 32'd0);
        checkOutput("mid rst inst_out", bus.inst_out, 32'h0000_0013);
        checkOutput("mid rst inst_pc", bus.inst_pc, 32'h0);
      end
      if (i == 12) checkOutput("mid restart addr", bus.imem_addr, 32'h0);
      if (i == 17) checkOutput("mid restart inst_pc", bus.inst_pc, 32'h0);
    end

    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    $display("[TB] %0d tests run, %0d failed", testsRun, failures);
    $finish;
  end
endmodule

// File: doc/ifetch_prefetch.md
# ifetch_prefetch

Instruction fetch front-end placed directly upstream of the single-cycle RISC-V core. It runs the fetch PC, issues word reads to an instruction memory that may insert wait states, and buffers the returned {PC, instruction} pairs in a small FIFO. The core consumes these pairs through a valid/ready handshake. The core redirects fetch on taken branches and jumps; a redirect flushes all buffered and in-flight instructions.

## Interface
- `DEPTH`, default 4: FIFO entries. Power of two, ≥2.
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset. Word-aligned.
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: reset. Synchronous and active-high.
- `imem_req`  out  1: one-cycle pulse that issues a read of `imem_addr`.
- `imem_addr`  out  32: fetch address. Bits [1:0] are always 0.
- `imem_rvalid`  in  1: read data valid. Arrives ≥1 cycle after its `imem_req`.
- `imem_rdata`  in  32: instruction word for the oldest outstanding request.
- `redirect_valid`  in  1: core requests a fetch-PC change this cycle.
- `redirect_pc`  in  32: new fetch PC. Bits [1:0] are ignored (forced to 0).
- `inst_valid`  out  1: FIFO head is valid.
- `inst_ready`  in  1: core accepts the head this cycle.
- `inst_out`  out  32: head instruction, or 32'h0000_0013 (NOP) when `inst_valid`=0.
- `inst_pc`  out  32: head PC, or 0 when `inst_valid`=0.

## Operation
- At most one memory request is outstanding at any time. Responses return in order.
- FSM states:
  - IDLE: no request outstanding.
  - WAIT: one request outstanding; its response will be pushed.
  - DROP: one request outstanding; its response will be discarded.
- Issue condition:
  - Not in a `redirect_valid` cycle, and
  - after this cycle's push and pop, no request remains outstanding, and
  - next-cycle FIFO count < DEPTH.
- On issue: `imem_req`=1, `imem_addr`=fetch_pc, and fetch_pc advances by 4.
- IDLE → WAIT on issue.
- WAIT on `imem_rvalid`:
  - Push {issued PC, `imem_rdata`}.
  - Go to WAIT if a new request is issued in the same cycle, otherwise IDLE.
- WAIT on `redirect_valid` without `imem_rvalid` → DROP.
- WAIT on `redirect_valid` together with `imem_rvalid`: the response is discarded → IDLE.
- DROP on `imem_rvalid`: discard the data, then → WAIT if a request is issued that cycle, else IDLE.
- DROP on `redirect_valid`: update fetch_pc and stay in DROP.
- `redirect_valid` in any state:
  - fetch_pc ← {`redirect_pc`[31:2], 2'b00}.
  - FIFO is flushed (count, read pointer and write pointer go to 0).
  - A pop in that same cycle is void.
  - The redirect target is requested no earlier than the next cycle.
- Pop: when `inst_valid` & `inst_ready`, the head advances.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Count is log2(DEPTH)+1 bits.
- fetch_pc wraps 32'hFFFF_FFFC → 0 with no error.
- Push into a full FIFO cannot occur by construction. The bench asserts this.

## Timing
- Reset values, taking effect in the cycle after `rst` is sampled high:
  - `imem_req`=0, `imem_addr`=RESET_PC
  - `inst_valid`=0, `inst_out`=32'h13, `inst_pc`=0
  - state IDLE, count 0, fetch_pc=RESET_PC
- `rst` asserted mid-transaction behaves like a power-on reset. A late `imem_rvalid` from before reset is ignored while in IDLE.
- First `imem_req` occurs in the first cycle with `rst`=0.
- Latency: `imem_rvalid` in cycle n → `inst_valid`=1 with that entry in cycle n+1.
- 1-cycle memory with `inst_ready` held high: one instruction per cycle after a 2-cycle fill.
- `redirect_valid` in cycle n:
  - `inst_valid`=0 in cycle n+1.
  - Target request in cycle n+1 if IDLE, otherwise in the cycle its DROP response returns.
- `imem_req` and `imem_addr` are decoded from registered state. They have no combinational path from `imem_rvalid` except issue-on-response. They have no combinational path from `inst_ready`.
- `inst_*` outputs come from FIFO registers only.

## Test plan
- Reset, 1-cycle memory, `inst_ready`=1:
  - `imem_addr` sequence 0, 4, 8, 12 on consecutive cycles.
  - `inst_pc` 0, 4, 8 on consecutive cycles starting 2 cycles after reset release.
- Backpressure, `inst_ready`=0, DEPTH=4:
  - Exactly 4 requests issued, then `imem_req` stays 0.
  - Raising `inst_ready` for 1 cycle pops PC 0 and triggers exactly one new request (addr 16).
- Memory with 3 wait states: `imem_req` spaced 4 cycles apart. No second request while outstanding.
- `redirect_valid` with `redirect_pc`=32'h0000_0103 while in WAIT:
  - FIFO empties next cycle.
  - The stale response is dropped, the next `imem_addr`=32'h100, and the first delivered `inst_pc`=32'h100.
- Corner cases:
  - Redirect in the same cycle as `imem_rvalid` and `inst_ready`: the response is discarded, the pop is void, and state goes to IDLE.
  - Redirect during DROP: the last target wins.
- Wrap and mid-run reset:
  - RESET_PC=32'hFFFF_FFF8 fetches FFF8, FFFC, 0000_0000.
  - `rst` asserted mid-WAIT returns all outputs to reset values the next cycle.
